// File: rtl/dram_test_sequencer_if.sv
// rtl/dram_test_sequencer_if.sv - LiteDRAM native user port bundle
// Purpose: groups the native command, write-data and read-data channels
//   between the test sequencer and the litedram_core user port.
// Signals:
//   cmd_valid/cmd_ready/cmd_we/cmd_addr          command channel
//   wdata_valid/wdata_ready/wdata_we/wdata_data  write-data channel
//   rdata_valid/rdata_ready/rdata_data           read-data channel
// Modports: master = sequencer side, slave = core/memory side.
interface dram_test_sequencer_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_we;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_W/8-1:0]   wdata_we;
  logic [DATA_W-1:0]     wdata_data;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_W-1:0]     rdata_data;

  modport master (
    output cmd_valid, cmd_we, cmd_addr,
    input  cmd_ready,
    output wdata_valid, wdata_we, wdata_data,
    input  wdata_ready,
    input  rdata_valid, rdata_data,
    output rdata_ready
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr,
    output cmd_ready,
    input  wdata_valid, wdata_we, wdata_data,
    output wdata_ready,
    output rdata_valid, rdata_data,
    input  rdata_ready
  );
endinterface

// File: rtl/dram_test_sequencer.sv
// rtl/dram_test_sequencer.sv - write/read-back test controller for a LiteDRAM native port
// Purpose: writes an address-derived pattern to count consecutive native
//   addresses from base_addr, reads each back, and reports pass/fail,
//   a saturating error count and the first failing address.
// Ports:
//   user_clk, user_rst     clock, synchronous active-high reset
//   start, abort           run control (start sampled in IDLE/DONE only)
//   base_addr, count       run window, latched on start
//   native                 native user port (master side)
//   busy, done             run status
//   pass, aborted          result flags, valid while done
//   err_count              mismatching words, saturating
//   first_err_addr         address of first mismatch, 0 if none
module dram_test_sequencer #(
  parameter int          ADDR_W = 25,
  parameter int          DATA_W = 256,
  parameter logic [31:0] SEED   = 32'hA5A5_0000,
  parameter int          ERR_W  = 16
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W-1:0]     count,
  dram_test_sequencer_if.master native,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  aborted,
  output logic [ERR_W-1:0]      err_count,
  output logic [ADDR_W-1:0]     first_err_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_CMD,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] idx;
  logic              cmd_acc;
  logic              wd_acc;
  logic              abort_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] first_err_q;
  logic              pass_q;
  logic              aborted_q;

  logic [ADDR_W-1:0] cur_addr;
  logic              last_idx;
  logic              busy_c;
  logic              abort_eff;
  logic              rd_mismatch;

  logic              load;
  logic              cmd_valid_c;
  logic              cmd_we_c;
  logic              wdata_valid_c;
  logic              rdata_ready_c;
  logic              cmd_ok;
  logic              wd_ok;
  logic              wr_beat;
  logic              abort_take;
  logic              rd_beat;

  // 32-bit word {0, A} ^ SEED replicated across the data width.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a) ^ SEED;
    return {(DATA_W/32){w}};
  endfunction

  assign cur_addr    = base_q + idx;
  assign last_idx    = (idx == count_q - ADDR_W'(1));
  assign busy_c      = (state == S_WR) || (state == S_RD_CMD) || (state == S_RD_DATA);
  // A pulse on abort is remembered so it is honoured at the next boundary.
  assign abort_eff   = abort || abort_q;
  assign rd_mismatch = (native.rdata_data != pattern(cur_addr));

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    load          = 1'b0;
    cmd_valid_c   = 1'b0;
    cmd_we_c      = 1'b0;
    wdata_valid_c = 1'b0;
    rdata_ready_c = 1'b0;
    cmd_ok        = 1'b0;
    wd_ok         = 1'b0;
    wr_beat       = 1'b0;
    abort_take    = 1'b0;
    rd_beat       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (count == '0) ? S_DONE : S_WR;
        end
      end
      S_WR: begin
        // Boundary = no half-finished write; an abort there presents nothing new.
        if (!cmd_acc && !wd_acc && abort_eff) begin
          abort_take = 1'b1;
          state_next = S_DONE;
        end else begin
          cmd_valid_c   = !cmd_acc;
          cmd_we_c      = !cmd_acc;
          wdata_valid_c = !wd_acc;
          cmd_ok        = cmd_acc || native.cmd_ready;
          wd_ok         = wd_acc || native.wdata_ready;
          if (cmd_ok && wd_ok) begin
            wr_beat = 1'b1;
            if (last_idx) begin
              state_next = S_RD_CMD;
            end
          end
        end
      end
      S_RD_CMD: begin
        if (abort_eff) begin
          abort_take = 1'b1;
          state_next = S_DONE;
        end else begin
          cmd_valid_c = 1'b1;
          if (native.cmd_ready) begin
            state_next = S_RD_DATA;
          end
        end
      end
      S_RD_DATA: begin
        // The outstanding read is always drained; a pending abort waits.
        rdata_ready_c = 1'b1;
        if (native.rdata_valid) begin
          rd_beat    = 1'b1;
          state_next = last_idx ? S_DONE : S_RD_CMD;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      base_q      <= '0;
      count_q     <= '0;
      idx         <= '0;
      cmd_acc     <= 1'b0;
      wd_acc      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else if (load) begin
      base_q      <= base_addr;
      count_q     <= count;
      idx         <= '0;
      cmd_acc     <= 1'b0;
      wd_acc      <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= '0;
      first_err_q <= '0;
      pass_q      <= (count == '0);
      aborted_q   <= 1'b0;
    end else begin
      if (busy_c && abort) begin
        abort_q <= 1'b1;
      end
      if (state == S_WR && !abort_take) begin
        if (wr_beat) begin
          cmd_acc <= 1'b0;
          wd_acc  <= 1'b0;
          idx     <= last_idx ? '0 : idx + ADDR_W'(1);
        end else begin
          cmd_acc <= cmd_ok;
          wd_acc  <= wd_ok;
        end
      end
      if (abort_take) begin
        aborted_q <= 1'b1;
        pass_q    <= 1'b0;
      end
      if (rd_beat) begin
        if (rd_mismatch) begin
          if (err_q != '1) begin
            err_q <= err_q + ERR_W'(1);
          end
          // err_q saturates rather than wrapping, so zero means no error yet.
          if (err_q == '0) begin
            first_err_q <= cur_addr;
          end
        end
        if (last_idx) begin
          pass_q <= (err_q == '0) && !rd_mismatch;
        end else begin
          idx <= idx + ADDR_W'(1);
        end
      end
    end
  end

  assign native.cmd_valid   = cmd_valid_c;
  assign native.cmd_we      = cmd_we_c;
  assign native.cmd_addr    = cmd_valid_c ? cur_addr : '0;
  assign native.wdata_valid = wdata_valid_c;
  assign native.wdata_we    = {(DATA_W/8){wdata_valid_c}};
  assign native.wdata_data  = wdata_valid_c ? pattern(cur_addr) : '0;
  assign native.rdata_ready = rdata_ready_c;

  assign busy           = busy_c;
  assign done           = (state == S_DONE);
  assign pass           = pass_q;
  assign aborted        = aborted_q;
  assign err_count      = err_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_dram_test_sequencer.sv
// tb/tb_dram_test_sequencer.sv - self-checking bench for dram_test_sequencer
module tb_dram_test_sequencer;
  localparam int AW = 25;
  localparam int DW = 256;
  localparam int EW = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
  } cmd_t;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] count = '0;
  logic          busy, done, pass, aborted;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;

  int total = 0;
  int bad = 0;

  dram_test_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) nif ();

  dram_test_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .SEED(32'hA5A5_0000), .ERR_W(EW)
  ) dut (
    .user_clk(user_clk), .user_rst(user_rst), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .native(nif),
    .busy(busy), .done(done), .pass(pass), .aborted(aborted),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 user_clk = ~user_clk;

  // scoreboard and memory model state
  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_wd[$];
  logic [AW-1:0] wq[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  bit            corrupt_set[logic [AW-1:0]];
  bit            corrupt_all = 0;
  int            wd_lag = 0;
  int            wd_cnt = 0;
  bit            cmd_seen = 0;
  bit            rd_pend = 0;
  logic [AW-1:0] rd_addr = '0;
  int            wr_cmd_cnt = 0;
  int            split_cycles = 0;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [31:0] w;
    w = {7'b0, a} ^ 32'hA5A5_0000;
    return {8{w}};
  endfunction

  // Memory model: drives responses on the falling edge, then samples the
  // handshakes that the next rising edge will complete.
  initial begin
    logic [DW-1:0] d;
    cmd_t          got;
    cmd_t          want;
    logic [DW-1:0] wwant;
    logic [AW-1:0] wa;
    nif.cmd_ready   = 1'b0;
    nif.wdata_ready = 1'b0;
    nif.rdata_valid = 1'b0;
    nif.rdata_data  = '0;
    forever begin
      @(negedge user_clk);
      nif.cmd_ready   = 1'b1;
      nif.wdata_ready = (wd_lag == 0) || (cmd_seen && wd_cnt >= wd_lag);
      nif.rdata_valid = rd_pend;
      if (rd_pend) begin
        d = mem.exists(rd_addr) ? mem[rd_addr] : '0;
        if (corrupt_all || corrupt_set.exists(rd_addr)) d[0] = ~d[0];
        nif.rdata_data = d;
      end else begin
        nif.rdata_data = '0;
      end
      #2;
      if (user_rst) begin
        rd_pend  = 0;
        cmd_seen = 0;
        wq.delete();
      end else begin
        if (cmd_seen) wd_cnt++;
        if (nif.wdata_valid && !nif.cmd_valid) split_cycles++;
        if (nif.cmd_valid && nif.cmd_ready) begin
          got = {nif.cmd_we, nif.cmd_addr};
          total++;
          if (exp_cmd.size() == 0) begin
            bad++;
            $display("FAIL cmd_unexpected: got we=%0d addr=%h, none expected", got.we, got.addr);
          end else begin
            want = exp_cmd.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL cmd_order: got we=%0d addr=%h want we=%0d addr=%h",
                       got.we, got.addr, want.we, want.addr);
            end
          end
          if (nif.cmd_we) begin
            wq.push_back(nif.cmd_addr);
            wr_cmd_cnt++;
            cmd_seen = 1;
            wd_cnt   = 1;
          end else begin
            rd_pend = 1;
            rd_addr = nif.cmd_addr;
          end
        end
        if (nif.wdata_valid && nif.wdata_ready) begin
          total++;
          if (exp_wd.size() == 0) begin
            bad++;
            $display("FAIL wdata_unexpected: got %h, none expected", nif.wdata_data[31:0]);
          end else begin
            wwant = exp_wd.pop_front();
            if (nif.wdata_data !== wwant || nif.wdata_we !== {(DW/8){1'b1}}) begin
              bad++;
              $display("FAIL wdata: got word %h be %h want word %h be all ones",
                       nif.wdata_data[31:0], nif.wdata_we, wwant[31:0]);
            end
          end
          wa = (wq.size() > 0) ? wq.pop_front() : '0;
          mem[wa]  = nif.wdata_data;
          cmd_seen = 0;
        end
        if (nif.rdata_valid && nif.rdata_ready) rd_pend = 0;
      end
    end
  end

  task automatic push_expect(input logic [AW-1:0] b, input int n_wr, input int n_rd);
    logic [AW-1:0] a;
    for (int i = 0; i < n_wr; i++) begin
      a = b + AW'(i);
      exp_cmd.push_back({1'b1, a});
      exp_wd.push_back(pat(a));
    end
    for (int i = 0; i < n_rd; i++) begin
      a = b + AW'(i);
      exp_cmd.push_back({1'b0, a});
    end
  endtask

  task automatic start_and_wait(input logic [AW-1:0] b, input logic [AW-1:0] c,
                                input int budget, output int cyc, output bit to);
    @(negedge user_clk);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < budget) begin
      @(negedge user_clk);
      cyc++;
    end
    to = !done;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge user_clk);
    user_rst = 1'b0;
    total++;
    if ({nif.cmd_valid, nif.wdata_valid, nif.rdata_ready, busy, done, pass, aborted} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {nif.cmd_valid, nif.wdata_valid, nif.rdata_ready, busy, done, pass, aborted});
    end
    total++;
    if (nif.wdata_we !== '0 || nif.cmd_addr !== '0) begin
      bad++;
      $display("FAIL reset_bus: got be=%h addr=%h want 0", nif.wdata_we, nif.cmd_addr);
    end
    total++;
    if (err_count !== '0 || first_err_addr !== '0) begin
      bad++;
      $display("FAIL reset_err: got err=%0d first=%h want 0", err_count, first_err_addr);
    end
  endtask

  task automatic test_basic;
    int cyc;
    bit to;
    push_expect(25'h10, 4, 4);
    start_and_wait(25'h10, 25'd4, 200, cyc, to);
    total++;
    if (to || cyc > 14) begin
      bad++;
      $display("FAIL basic_latency: got %0d cycles (timeout=%0d) want <= 14", cyc, to);
    end
    total++;
    if ({pass, aborted, busy} !== 3'b100 || err_count !== 0 || first_err_addr !== 0) begin
      bad++;
      $display("FAIL basic_result: got pass=%0d ab=%0d busy=%0d err=%0d first=%h want 1 0 0 0 0",
               pass, aborted, busy, err_count, first_err_addr);
    end
    total++;
    if (exp_cmd.size() != 0 || exp_wd.size() != 0) begin
      bad++;
      $display("FAIL basic_drain: got %0d cmd %0d wdata left want 0", exp_cmd.size(), exp_wd.size());
    end
  endtask

  task automatic test_split;
    int cyc;
    bit to;
    wd_lag       = 3;
    split_cycles = 0;
    push_expect(25'h40, 4, 4);
    start_and_wait(25'h40, 25'd4, 400, cyc, to);
    wd_lag = 0;
    total++;
    if (to || pass !== 1'b1) begin
      bad++;
      $display("FAIL split_result: got pass=%0d timeout=%0d want pass=1", pass, to);
    end
    total++;
    if (split_cycles != 12) begin
      bad++;
      $display("FAIL split_hold: got %0d cycles wdata-only want 12", split_cycles);
    end
    total++;
    if (exp_cmd.size() != 0 || exp_wd.size() != 0) begin
      bad++;
      $display("FAIL split_drain: got %0d cmd %0d wdata left want 0", exp_cmd.size(), exp_wd.size());
    end
  endtask

  task automatic test_fault;
    int cyc;
    bit to;
    corrupt_set[25'h12] = 1;
    corrupt_set[25'h13] = 1;
    push_expect(25'h10, 4, 4);
    start_and_wait(25'h10, 25'd4, 200, cyc, to);
    corrupt_set.delete();
    total++;
    if (to || err_count !== 4'd2 || first_err_addr !== 25'h12) begin
      bad++;
      $display("FAIL fault_count: got err=%0d first=%h timeout=%0d want err=2 first=0000012",
               err_count, first_err_addr, to);
    end
    total++;
    if (pass !== 1'b0 || aborted !== 1'b0) begin
      bad++;
      $display("FAIL fault_pass: got pass=%0d ab=%0d want 0 0", pass, aborted);
    end
  endtask

  task automatic test_zero_count;
    int cyc;
    bit to;
    start_and_wait(25'h77, 25'd0, 50, cyc, to);
    total++;
    if (to || cyc != 1 || pass !== 1'b1) begin
      bad++;
      $display("FAIL zero_done: got cyc=%0d pass=%0d want cyc=1 pass=1", cyc, pass);
    end
    total++;
    if (err_count !== 0 || first_err_addr !== 0) begin
      bad++;
      $display("FAIL zero_clear: got err=%0d first=%h want 0 0", err_count, first_err_addr);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    bit to;
    push_expect(25'h1FF_FFFE, 3, 3);
    start_and_wait(25'h1FF_FFFE, 25'd3, 200, cyc, to);
    total++;
    if (to || pass !== 1'b1) begin
      bad++;
      $display("FAIL wrap_result: got pass=%0d timeout=%0d want 1", pass, to);
    end
    total++;
    if (exp_cmd.size() != 0) begin
      bad++;
      $display("FAIL wrap_drain: got %0d cmd left want 0", exp_cmd.size());
    end
  endtask

  task automatic test_abort;
    int cyc;
    int wr0;
    wd_lag = 3;
    wr0    = wr_cmd_cnt;
    push_expect(25'h20, 3, 0);
    @(negedge user_clk);
    base_addr = 25'h20;
    count     = 25'd6;
    start     = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    cyc   = 0;
    while (wr_cmd_cnt < wr0 + 3 && cyc < 200) begin
      @(negedge user_clk);
      cyc++;
    end
    total++;
    if (nif.wdata_valid !== 1'b1 || nif.cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_partial: got wdv=%0d cv=%0d want 1 0", nif.wdata_valid, nif.cmd_valid);
    end
    abort = 1'b1;
    @(negedge user_clk);
    abort = 1'b0;
    cyc   = 0;
    while (!done && cyc < 200) begin
      @(negedge user_clk);
      cyc++;
    end
    wd_lag = 0;
    total++;
    if (!done || aborted !== 1'b1 || pass !== 1'b0) begin
      bad++;
      $display("FAIL abort_result: got done=%0d ab=%0d pass=%0d want 1 1 0", done, aborted, pass);
    end
    total++;
    if (wr_cmd_cnt - wr0 != 3 || exp_cmd.size() != 0 || exp_wd.size() != 0) begin
      bad++;
      $display("FAIL abort_writes: got %0d writes, %0d/%0d left want 3 writes 0 left",
               wr_cmd_cnt - wr0, exp_cmd.size(), exp_wd.size());
    end
  endtask

  task automatic test_saturation_reset;
    int cyc;
    bit to;
    corrupt_all = 1;
    push_expect(25'h100, 20, 20);
    start_and_wait(25'h100, 25'd20, 1000, cyc, to);
    total++;
    if (to || err_count !== 4'hF || first_err_addr !== 25'h100 || pass !== 1'b0) begin
      bad++;
      $display("FAIL sat_count: got err=%0d first=%h pass=%0d want 15 0000100 0",
               err_count, first_err_addr, pass);
    end
    push_expect(25'h100, 20, 1);
    @(negedge user_clk);
    start = 1'b1;
    @(negedge user_clk);
    start = 1'b0;
    cyc   = 0;
    while (!nif.rdata_ready && cyc < 500) begin
      @(negedge user_clk);
      cyc++;
    end
    total++;
    if (!nif.rdata_ready || !busy) begin
      bad++;
      $display("FAIL rst_reach_rd: got rdata_ready=%0d busy=%0d want 1 1", nif.rdata_ready, busy);
    end
    user_rst = 1'b1;
    @(negedge user_clk);
    total++;
    if ({nif.cmd_valid, nif.wdata_valid, nif.rdata_ready, busy, done, pass, aborted} !== 7'b0 ||
        err_count !== '0 || first_err_addr !== '0 || nif.wdata_we !== '0) begin
      bad++;
      $display("FAIL rst_midrun: got flags=%b err=%0d first=%h want all 0",
               {nif.cmd_valid, nif.wdata_valid, nif.rdata_ready, busy, done, pass, aborted},
               err_count, first_err_addr);
    end
    user_rst    = 1'b0;
    corrupt_all = 0;
    @(negedge user_clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || nif.cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle: got busy=%0d done=%0d cv=%0d want 0 0 0", busy, done, nif.cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_fault();
    test_zero_count();
    test_wrap();
    test_abort();
    test_saturation_reset();
    repeat (2) @(negedge user_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
